// File: rtl/exec_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Latency: XLEN/UNROLL + 1 cycles from acceptance; divide-by-zero and signed overflow answer in 1 cycle.
// Backpressure: stall_ao holds execute until the valid_o cycle; ready_o accepts only in IDLE; squash aborts.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   valid_i, op_i      request strobe and operation (MUL..REMU encoded 0..7)
//   a_i, b_i           rs1 / rs2 operands
//   squash_i           abort any in-flight operation, block acceptance
//   ready_o            idle, can accept
//   stall_ao           combinational stall request towards hazard logic
//   valid_o, result_o  one-cycle result pulse; result_o holds between pulses
module exec_muldiv_unit #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            squash_i,
   output logic            ready_o,
   output logic            stall_ao,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o
);
   localparam int N  = XLEN / UNROLL;
   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e          state_q, state_d;
   logic [2:0]      op_q;
   logic            a_neg_q, b_neg_q;
   logic [XLEN-1:0] m_q;          // multiplicand (multiply) or divisor (divide) magnitude
   logic [XLEN-1:0] hi_q, lo_q;   // mul: {partial sum, multiplier}; div: {remainder, dividend->quotient}
   logic [CW-1:0]   cnt_q;
   logic            valid_q;
   logic [XLEN-1:0] result_q;

   // ---------------- request decode ----------------
   logic            a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, div_ovf, fast, accept;
   logic [XLEN-1:0] a_mag, b_mag, fast_res;

   always_comb begin
      a_sgn    = !(op_i == 3'd3 || op_i == 3'd5 || op_i == 3'd7);
      b_sgn    = a_sgn && (op_i != 3'd2);
      a_neg    = a_sgn & a_i[XLEN-1];
      b_neg    = b_sgn & b_i[XLEN-1];
      a_mag    = a_neg ? -a_i : a_i;
      b_mag    = b_neg ? -b_i : b_i;
      is_div   = op_i[2];
      div_zero = is_div && (b_i == '0);
      // Only signed DIV/REM (op bit 0 clear) can overflow.
      div_ovf  = is_div && !op_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
      fast     = div_zero | div_ovf;
      // op bit 1 selects remainder among the divide ops.
      if (div_zero) fast_res = op_i[1] ? a_i : '1;
      else          fast_res = op_i[1] ? '0  : a_i;
      accept   = valid_i & ready_o & ~squash_i;
   end

   // ---------------- UNROLL iteration steps ----------------
   logic [XLEN-1:0] hi_n, lo_n;
   logic [XLEN:0]   rem_t, sum;
   logic            qbit;

   always_comb begin
      hi_n  = hi_q;
      lo_n  = lo_q;
      rem_t = '0;
      sum   = '0;
      qbit  = 1'b0;
      for (int i = 0; i < UNROLL; i++) begin
         if (op_q[2]) begin
            // Restoring division: shift in the next dividend bit, subtract if it fits.
            rem_t = {hi_n, lo_n[XLEN-1]};
            qbit  = (rem_t >= {1'b0, m_q});
            if (qbit) rem_t = rem_t - {1'b0, m_q};
            hi_n  = rem_t[XLEN-1:0];
            lo_n  = {lo_n[XLEN-2:0], qbit};
         end else begin
            // Shift-add: the multiplier drains out of lo as product bits shift in.
            sum  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo_n[XLEN-1:1]};
         end
      end
   end

   // ---------------- sign correction and result select ----------------
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, run_res;

   always_comb begin
      prod = {hi_n, lo_n};
      if (a_neg_q ^ b_neg_q) prod = -prod;
      quo = lo_n;
      if (a_neg_q ^ b_neg_q) quo = -quo;
      rem = hi_n;
      if (a_neg_q) rem = -rem;
      unique case (op_q)
         3'd0:             run_res = prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3: run_res = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:       run_res = quo;
         default:          run_res = rem;
      endcase
   end

   // ---------------- FSM ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = fast ? DONE : RUN;
         RUN: begin
            if (squash_i)                 state_d = IDLE;
            else if (cnt_q == CW'(1))     state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         m_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         // A squash in the last RUN cycle diverts state_d to IDLE, so no pulse.
         valid_q <= (state_d == DONE);
         if (accept) begin
            op_q    <= op_i;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            m_q     <= is_div ? b_mag : a_mag;
            hi_q    <= '0;
            lo_q    <= is_div ? a_mag : b_mag;
            cnt_q   <= CW'(N);
            if (fast) result_q <= fast_res;
         end else if (state_q == RUN && !squash_i) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) result_q <= run_res;
         end
      end
   end

   assign ready_o  = (state_q == IDLE);
   assign valid_o  = valid_q;
   assign result_o = result_q;
   assign stall_ao = valid_i & ~valid_o & ~squash_i;

endmodule
